// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Turns the UART receiver's byte stream into framed messages for the
//   WimpFi receive path. The wire format is SYNC, LEN, LEN payload bytes,
//   CSUM. The 8-bit sum of LEN, the payload and CSUM must be zero.
//   Payload bytes are streamed into a downstream frame buffer as they
//   arrive. The buffer is then told to publish the frame (commit) or to
//   drop it (abort).
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active low
//   rx_valid     in   receiver holds a byte
//   rx_data      in   receiver byte [7:0]
//   rx_ferr      in   framing error qualifying rx_data
//   rx_oerr      in   overrun error qualifying rx_data
//   rx_rdy       out  byte accepted this cycle (combinational)
//   buf_full     in   frame buffer cannot take a write
//   wr_en        out  payload write strobe (registered)
//   wr_data      out  payload byte [7:0] (registered)
//   frame_commit out  1-cycle pulse: frame good
//   frame_abort  out  1-cycle pulse: discard bytes since last commit/abort
//   frame_len    out  LEN of current/last frame [7:0]
//   busy         out  not hunting for SYNC
//   drop_cnt     out  saturating count of aborted frames [7:0]
module uart_rx_frame_ctrl #(
  parameter int         CLK_HZ      = 100_000_000,
  parameter int         TIMEOUT_CYC = CLK_HZ / 100,
  parameter int         MAX_LEN     = 32,
  parameter logic [7:0] SYNC_BYTE   = 8'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_ferr,
  input  logic       rx_oerr,
  output logic       rx_rdy,
  input  logic       buf_full,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       frame_commit,
  output logic       frame_abort,
  output logic [7:0] frame_len,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int               TMO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_ABORT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       sum;
  logic [7:0]       remaining;
  logic [TMO_W-1:0] tmo_cnt;

  logic       acc;
  logic       bad;
  logic       tmo_hit;
  logic [7:0] csum_chk;
  logic       len_ld;
  logic       wr_nxt;
  logic       commit_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign acc         = rx_valid & rx_rdy;
  assign bad         = rx_ferr | rx_oerr;
  assign tmo_hit     = (tmo_cnt == TMO_LAST);
  assign csum_chk    = sum + rx_data;
  assign frame_abort = (state == S_ABORT);
  assign busy        = (state != S_HUNT);

  // Next-state, handshake and strobes. An accepted byte always takes
  // priority over a timeout occurring in the same cycle.
  always_comb begin
    state_nxt  = state;
    rx_rdy     = 1'b0;
    len_ld     = 1'b0;
    wr_nxt     = 1'b0;
    commit_nxt = 1'b0;
    case (state)
      S_HUNT: begin
        rx_rdy = 1'b1;
        if (acc && !bad && rx_data == SYNC_BYTE) state_nxt = S_LEN;
      end
      S_LEN: begin
        rx_rdy = 1'b1;
        if (acc) begin
          if (bad || rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            state_nxt = S_ABORT;
          end else begin
            len_ld    = 1'b1;
            state_nxt = S_PAYLOAD;
          end
        end else if (tmo_hit) begin
          state_nxt = S_ABORT;
        end
      end
      S_PAYLOAD: begin
        rx_rdy = !buf_full;
        if (acc) begin
          if (bad) begin
            state_nxt = S_ABORT;
          end else begin
            wr_nxt = 1'b1;
            if (remaining == 8'd1) state_nxt = S_CSUM;
          end
        end else if (tmo_hit) begin
          state_nxt = S_ABORT;
        end
      end
      S_CSUM: begin
        rx_rdy = 1'b1;
        if (acc) begin
          if (!bad && csum_chk == 8'd0) begin
            commit_nxt = 1'b1;
            state_nxt  = S_HUNT;
          end else begin
            state_nxt = S_ABORT;
          end
        end else if (tmo_hit) begin
          state_nxt = S_ABORT;
        end
      end
      S_ABORT: begin
        state_nxt = S_HUNT;
      end
      default: begin
        state_nxt = S_HUNT;
      end
    endcase
  end

  // Registered state, datapath and outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_HUNT;
      sum          <= 8'd0;
      remaining    <= 8'd0;
      tmo_cnt      <= '0;
      wr_en        <= 1'b0;
      wr_data      <= 8'd0;
      frame_commit <= 1'b0;
      frame_len    <= 8'd0;
      drop_cnt     <= 8'd0;
    end else begin
      state        <= state_nxt;
      wr_en        <= wr_nxt;
      frame_commit <= commit_nxt;

      if (len_ld) begin
        frame_len <= rx_data;
        remaining <= rx_data;
        sum       <= rx_data;
      end else if (wr_nxt) begin
        remaining <= remaining - 8'd1;
        sum       <= csum_chk;
      end

      if (wr_nxt) wr_data <= rx_data;

      // Idle-gap counter; only meaningful while a frame is in progress.
      if (acc || state == S_HUNT) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + TMO_W'(1);

      // Count each abort once, on entry to the ABORT state.
      if (state != S_ABORT && state_nxt == S_ABORT) drop_cnt <= sat_inc8(drop_cnt);
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic       rx_oerr;
  logic       rx_rdy;
  logic       buf_full;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       frame_commit;
  logic       frame_abort;
  logic [7:0] frame_len;
  logic       busy;
  logic [7:0] drop_cnt;

  uart_rx_frame_ctrl #(
    .TIMEOUT_CYC(16),
    .MAX_LEN    (32),
    .SYNC_BYTE  (8'h7E)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ferr     (rx_ferr),
    .rx_oerr     (rx_oerr),
    .rx_rdy      (rx_rdy),
    .buf_full    (buf_full),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .frame_commit(frame_commit),
    .frame_abort (frame_abort),
    .frame_len   (frame_len),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  logic [7:0] wr_q[$];
  int         n_commit = 0;
  int         n_abort  = 0;
  int         n_both   = 0;
  logic [7:0] commit_len = 8'd0;
  int         abort_cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int last_acc_cyc = 0;
  int bw, bc, ba;

  always @(posedge clk) cyc <= cyc + 1;

  // Output log, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) wr_q.push_back(wr_data);
    if (frame_commit) begin
      n_commit   = n_commit + 1;
      commit_len = frame_len;
    end
    if (frame_abort) begin
      n_abort   = n_abort + 1;
      abort_cyc = cyc;
    end
    if (frame_commit && frame_abort) n_both = n_both + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one byte and hold it until accepted; returns on the falling
  // edge after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic fe, input logic oe);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = d;
    rx_ferr  = fe;
    rx_oerr  = oe;
    #1;
    while (!rx_rdy && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rx_rdy) check_val("rdy_wait", {31'd0, rx_rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    rx_oerr  = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic send(input logic [7:0] d);
    send_byte(d, 1'b0, 1'b0);
  endtask

  task automatic snap();
    bw = wr_q.size();
    bc = n_commit;
    ba = n_abort;
  endtask

  // Checks activity since the last snap(): write count, the first up to
  // four written bytes (pk holds byte 0 in its low byte), commits, aborts
  // and the drop counter.
  task automatic check_frame(input string tag, input int nw, input logic [31:0] pk,
                             input int nc, input int na, input logic [7:0] dexp);
    check_val({tag, "_wr_cnt"}, wr_q.size() - bw, nw);
    for (int i = 0; i < nw && i < 4; i++) begin
      if (bw + i < wr_q.size()) check_val({tag, "_wr_byte"}, {24'd0, wr_q[bw + i]}, {24'd0, pk[8*i +: 8]});
    end
    check_val({tag, "_commits"}, n_commit - bc, nc);
    check_val({tag, "_aborts"}, n_abort - ba, na);
    check_val({tag, "_drop_cnt"}, {24'd0, drop_cnt}, {24'd0, dexp});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lows;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    rx_ferr  = 1'b0;
    rx_oerr  = 1'b0;
    buf_full = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_wr_en",   {31'd0, wr_en},        32'd0);
    check_val("rst_wr_data", {24'd0, wr_data},      32'd0);
    check_val("rst_commit",  {31'd0, frame_commit}, 32'd0);
    check_val("rst_abort",   {31'd0, frame_abort},  32'd0);
    check_val("rst_busy",    {31'd0, busy},         32'd0);
    check_val("rst_len",     {24'd0, frame_len},    32'd0);
    check_val("rst_drop",    {24'd0, drop_cnt},     32'd0);
    check_val("rst_rdy",     {31'd0, rx_rdy},       32'd1);
    rst = 1'b1;
    idle(2);

    // Good frame
    snap();
    send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
    idle(3);
    check_frame("t1", 3, 32'h00332211, 1, 0, 8'd0);
    check_val("t1_len", {24'd0, commit_len}, 32'd3);
    check_val("t1_busy", {31'd0, busy}, 32'd0);

    // Garbage ahead of SYNC
    snap();
    send(8'h55); send(8'hAA); send(8'h7E); send(8'h01); send(8'h05); send(8'hFA);
    idle(3);
    check_frame("t2", 1, 32'h00000005, 1, 0, 8'd0);
    check_val("t2_len", {24'd0, commit_len}, 32'd1);

    // Bad checksum, then a good frame
    snap();
    send(8'h7E); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
    idle(3);
    check_frame("t3", 2, 32'h00000201, 0, 1, 8'd1);
    snap();
    send(8'h7E); send(8'h01); send(8'h05); send(8'hFA);
    idle(3);
    check_frame("t3b", 1, 32'h00000005, 1, 0, 8'd1);

    // Illegal lengths, then the largest legal length
    snap();
    send(8'h7E); send(8'h00);
    idle(3);
    send(8'h7E); send(8'h21);
    idle(3);
    check_frame("t4", 0, 32'h0, 0, 2, 8'd3);
    snap();
    send(8'h7E); send(8'h20);
    for (int i = 0; i < 32; i++) send(8'(i));
    send(8'hF0);
    idle(3);
    check_frame("t4max", 32, 32'h03020100, 1, 0, 8'd3);
    check_val("t4max_len", {24'd0, commit_len}, 32'h20);

    // Framing error on 2nd payload byte; overrun on LEN; errored SYNC ignored
    snap();
    send(8'h7E); send(8'h03); send(8'h10); send_byte(8'h20, 1'b1, 1'b0);
    idle(3);
    check_frame("t5f", 1, 32'h00000010, 0, 1, 8'd4);
    snap();
    send(8'h7E); send_byte(8'h05, 1'b0, 1'b1);
    idle(3);
    check_frame("t5o", 0, 32'h0, 0, 1, 8'd5);
    snap();
    send_byte(8'h7E, 1'b1, 1'b0); send(8'h01); send(8'h05); send(8'hFA);
    idle(3);
    check_frame("t5s", 0, 32'h0, 0, 0, 8'd5);
    check_val("t5s_busy", {31'd0, busy}, 32'd0);

    // Backpressure for 10 cycles mid-payload
    snap();
    send(8'h7E); send(8'h04); send(8'h01); send(8'h02);
    buf_full = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h03;
    lows = 0;
    repeat (10) begin
      #1;
      if (!rx_rdy) lows++;
      @(negedge clk);
    end
    check_val("t5b_rdy_low", lows, 10);
    check_val("t5b_stall_wr", wr_q.size() - bw, 2);
    buf_full = 1'b0;
    send(8'h03); send(8'h04); send(8'hF2);
    idle(3);
    check_frame("t5b", 4, 32'h04030201, 1, 0, 8'd5);

    // Timeout 16 cycles after the last accepted byte
    snap();
    send(8'h7E); send(8'h04); send(8'hAA);
    begin
      int t0;
      t0 = last_acc_cyc;
      idle(20);
      check_frame("t6a", 1, 32'h000000AA, 0, 1, 8'd6);
      check_val("t6a_delay", abort_cyc - t0, 16);
    end

    // Byte arriving on the last cycle before timeout keeps the frame alive
    snap();
    send(8'h7E); send(8'h04); send(8'hAA);
    idle(15);
    send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE);
    idle(3);
    check_frame("t6b", 4, 32'hDDCCBBAA, 1, 0, 8'd6);

    // Reset mid-payload
    snap();
    send(8'h7E); send(8'h04); send(8'hAA); send(8'hBB);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_val("t6c_wr_en",  {31'd0, wr_en},        32'd0);
    check_val("t6c_wdata",  {24'd0, wr_data},      32'd0);
    check_val("t6c_commit", {31'd0, frame_commit}, 32'd0);
    check_val("t6c_abort",  {31'd0, frame_abort},  32'd0);
    check_val("t6c_busy",   {31'd0, busy},         32'd0);
    check_val("t6c_len",    {24'd0, frame_len},    32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(20);
    check_frame("t6c", 2, 32'h0000BBAA, 0, 0, 8'd0);
    check_val("t6c_busy_after", {31'd0, busy}, 32'd0);

    check_val("commit_abort_overlap", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
